// File: rtl/score_player_pkg.sv
// score_pkg: key codes, 50 MHz note half-period table and player state encoding
package score_pkg;
    localparam int KEY_REST = 0;
    localparam logic [31:0] KEY_END = '1;
    localparam int HP_WIDTH = 17;

    typedef enum logic [2:0] {IDLE, FETCH, DECODE, PLAY, GAP} playerState;

    // Keys 1..14 are C4..B5 naturals; codes outside the table fall back to B5
    function automatic logic [HP_WIDTH-1:0] note_half_period(input int unsigned key);
        case (key)
            1:       return 17'd95555;
            2:       return 17'd85132;
            3:       return 17'd75843;
            4:       return 17'd71586;
            5:       return 17'd63776;
            6:       return 17'd56818;
            7:       return 17'd50620;
            8:       return 17'd47778;
            9:       return 17'd42566;
            10:      return 17'd37921;
            11:      return 17'd35793;
            12:      return 17'd31888;
            13:      return 17'd28409;
            default: return 17'd25310;
        endcase
    endfunction
endpackage

// File: rtl/score_player_tone_generator.sv
// tone_generator: square-wave toggle counter; Load restarts the phase, Enable gates and holds it
module tone_generator
    import score_pkg::*;
(
    input  logic                Clock,
    input  logic                Reset,
    input  logic                Enable,
    input  logic [HP_WIDTH-1:0] HalfPeriod,
    input  logic                Load,
    output logic                Speaker
);
    logic [HP_WIDTH-1:0] count;
    logic level;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            count <= '0;
            level <= 1'b0;
        end else if (Load) begin
            count <= HalfPeriod - HP_WIDTH'(1);
            level <= 1'b0;
        end else if (Enable) begin
            count <= count == '0 ? HalfPeriod - HP_WIDTH'(1) : count - HP_WIDTH'(1);
            level <= count == '0 ? ~level : level;
        end
    end

    assign Speaker = Enable & level;
endmodule

// File: rtl/score_player.sv
// score_player: multi-song score sequencer reading (key, duration) words and driving a speaker
module score_player
    import score_pkg::*;
#(
    parameter int SONG_BITS            = 2,
    parameter int OFFSET_BITS          = 5,
    parameter int KEY_WIDTH            = 4,
    parameter int TIME_WIDTH           = 4,
    parameter int BEAT_CYCLES          = 12_500_000,
    parameter int GAP_CYCLES           = 1_250_000,
    parameter int HALF_PERIOD_OVERRIDE = 0
) (
    input  logic                             Clock,
    input  logic                             Reset,
    input  logic                             Start,
    input  logic                             Stop,
    input  logic                             Pause,
    input  logic                             Loop,
    input  logic [SONG_BITS-1:0]             SongSel,
    output logic [SONG_BITS+OFFSET_BITS-1:0] ScoreAddr,
    input  logic [KEY_WIDTH-1:0]             ScoreKey,
    input  logic [TIME_WIDTH-1:0]            ScoreTime,
    output logic                             Speaker,
    output logic                             Busy,
    output logic                             Done
);
    localparam int OW = OFFSET_BITS;
    localparam int BW = TIME_WIDTH + 1;
    localparam int CW = $clog2(BEAT_CYCLES + 1);
    localparam int GW = $clog2(GAP_CYCLES + 2);

    playerState state, stateNext;
    logic [SONG_BITS-1:0] song, songNext;
    logic [OW-1:0] offset, offsetNext;
    logic [KEY_WIDTH-1:0] key, keyNext;
    logic [BW-1:0] beatCnt, beatNext;
    logic [CW-1:0] cycleCnt, cycleNext;
    logic [GW-1:0] gapCnt, gapNext;
    logic endFlag, endNext, paused, pausedNext, doneNext, load, nextWord;
    logic [HP_WIDTH-1:0] halfPeriod;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state    <= IDLE;
            song     <= '0;
            offset   <= '0;
            key      <= '0;
            beatCnt  <= '0;
            cycleCnt <= '0;
            gapCnt   <= '0;
            endFlag  <= 1'b0;
            paused   <= 1'b0;
            Done     <= 1'b0;
        end else begin
            state    <= stateNext;
            song     <= songNext;
            offset   <= offsetNext;
            key      <= keyNext;
            beatCnt  <= beatNext;
            cycleCnt <= cycleNext;
            gapCnt   <= gapNext;
            endFlag  <= endNext;
            paused   <= pausedNext;
            Done     <= doneNext;
        end
    end

    always_comb begin
        stateNext  = state;
        songNext   = song;
        offsetNext = offset;
        keyNext    = key;
        beatNext   = beatCnt;
        cycleNext  = cycleCnt;
        gapNext    = gapCnt;
        endNext    = endFlag;
        pausedNext = paused;
        doneNext   = 1'b0;
        load       = 1'b0;
        nextWord   = 1'b0;
        if (Stop) begin
            stateNext  = IDLE;
            pausedNext = 1'b0;
        end else begin
            if (!paused) begin
                case (state)
                    FETCH: stateNext = DECODE;
                    DECODE: begin
                        if (endFlag || ScoreKey == KEY_END[KEY_WIDTH-1:0]) begin
                            endNext    = 1'b0;
                            offsetNext = '0;
                            stateNext  = Loop ? FETCH : IDLE;
                            doneNext   = !Loop;
                        end else begin
                            stateNext = PLAY;
                            keyNext   = ScoreKey;
                            beatNext  = BW'(ScoreTime) + BW'(1);
                            cycleNext = CW'(BEAT_CYCLES - 1);
                            load      = 1'b1;
                        end
                    end
                    PLAY: begin
                        if (cycleCnt != '0)
                            cycleNext = cycleCnt - CW'(1);
                        else if (beatCnt != BW'(1)) begin
                            beatNext  = beatCnt - BW'(1);
                            cycleNext = CW'(BEAT_CYCLES - 1);
                        end else if (GAP_CYCLES != 0) begin
                            stateNext = GAP;
                            gapNext   = GW'(GAP_CYCLES - 1);
                        end else
                            nextWord = 1'b1;
                    end
                    GAP: begin
                        if (gapCnt != '0)
                            gapNext = gapCnt - GW'(1);
                        else
                            nextWord = 1'b1;
                    end
                    default: ;
                endcase
                // A wrapped offset re-reads word 0 of the same song, but the flag ends the score there
                if (nextWord) begin
                    stateNext  = FETCH;
                    offsetNext = offset + OW'(1);
                    endNext    = &offset;
                end
            end
            if (Start) begin
                stateNext  = FETCH;
                songNext   = SongSel;
                offsetNext = '0;
                endNext    = 1'b0;
                pausedNext = 1'b0;
            end else if (Pause && state != IDLE && stateNext != IDLE)
                pausedNext = !paused;
        end
    end

    assign halfPeriod = HALF_PERIOD_OVERRIDE != 0 ? HP_WIDTH'(HALF_PERIOD_OVERRIDE)
                      : note_half_period(32'(state == PLAY ? key : ScoreKey));

    tone_generator tone (
        .Clock      (Clock),
        .Reset      (Reset),
        .Enable     (state == PLAY && !paused && 32'(key) != KEY_REST),
        .HalfPeriod (halfPeriod),
        .Load       (load),
        .Speaker    (Speaker)
    );

    assign ScoreAddr = {song, offset};
    assign Busy      = state != IDLE;
endmodule

// File: tb/tb_score_player.sv
// tb_score_player: scenario bench comparing the player cycle by cycle against a per-note trace model
module tb_score_player;
    localparam int BEAT = 10;
    localparam int GAP  = 2;
    localparam int HALF = 4;
    localparam int OFFS = 32;

    logic clk = 1'b0, rstN = 1'b0, start = 1'b0, stop = 1'b0, pause = 1'b0, loop = 1'b0;
    logic [1:0] songSel = '0;
    logic [6:0] scoreAddr;
    logic [3:0] scoreKey, scoreTime;
    logic speaker, busy, done;
    logic [3:0] memKey [128];
    logic [3:0] memTime [128];
    int checks = 0, failures = 0;

    typedef struct {
        int addr;
        bit spk, busy, done, loop, start, stop, pause;
        int sel;
    } cycT;
    cycT q[$];

    score_player #(.BEAT_CYCLES(BEAT), .GAP_CYCLES(GAP), .HALF_PERIOD_OVERRIDE(HALF)) dut (
        .Clock(clk), .Reset(rstN), .Start(start), .Stop(stop), .Pause(pause), .Loop(loop),
        .SongSel(songSel), .ScoreAddr(scoreAddr), .ScoreKey(scoreKey), .ScoreTime(scoreTime),
        .Speaker(speaker), .Busy(busy), .Done(done));

    always #5 clk = ~clk;

    always @(posedge clk) begin
        scoreKey  <= memKey[scoreAddr];
        scoreTime <= memTime[scoreAddr];
    end

    function automatic cycT mk(int a, bit b, bit s, bit lp);
        cycT c;
        c.addr = a; c.busy = b; c.spk = s; c.loop = lp;
        c.done = 0; c.start = 0; c.stop = 0; c.pause = 0; c.sel = 0;
        return c;
    endfunction

    task automatic fillSong(int song, int len);
        for (int i = 0; i < OFFS; i++) begin
            memKey[song * OFFS + i]  = i == len ? 4'd15 : 4'($urandom_range(0, 14));
            memTime[song * OFFS + i] = 4'($urandom_range(0, 2));
        end
    endtask

    task automatic setBasicSong();
        memKey[0] = 4'd1;  memTime[0] = 4'd0;
        memKey[1] = 4'd0;  memTime[1] = 4'd1;
        memKey[2] = 4'd15; memTime[2] = 4'd0;
    endtask

    task automatic addIdle(int n);
        repeat (n) q.push_back(mk(0, 0, 0, 0));
    endtask

    task automatic addLaunch(int song);
        addIdle(1);
        q[q.size() - 1].start = 1;
        q[q.size() - 1].sel = song;
    endtask

    // Each word costs fetch+decode, then (t+1) beats of tone or silence, then the gap
    task automatic addSong(int song, int passes);
        for (int p = 0; p < passes; p++) begin
            bit lp = p < passes - 1;
            for (int i = 0; i <= OFFS; i++) begin
                int a = song * OFFS + i % OFFS;
                q.push_back(mk(a, 1, 0, lp));
                q.push_back(mk(a, 1, 0, lp));
                if (i == OFFS || memKey[a] == 4'd15) break;
                for (int j = 0; j < (int'(memTime[a]) + 1) * BEAT; j++)
                    q.push_back(mk(a, 1, memKey[a] != 0 && (j / HALF) % 2 == 1, lp));
                repeat (GAP) q.push_back(mk(a, 1, 0, lp));
            end
        end
        addIdle(1);
        q[q.size() - 1].done = 1;
        addIdle(1);
    endtask

    // A pause pulse at c freezes everything for n cycles with a silent speaker
    task automatic addPause(int c, int n);
        cycT f;
        f = q[c + 1];
        f.spk = 0; f.start = 0; f.stop = 0; f.pause = 0;
        for (int i = 0; i < n; i++) q.insert(c + 1, f);
        q[c].pause = 1;
        q[c + n].pause = 1;
    endtask

    task automatic runTrace(string name, int limit);
        for (int k = 0; k < limit; k++) begin
            @(negedge clk);
            checks++;
            if ({speaker, busy, done} !== {q[k].spk, q[k].busy, q[k].done}) begin
                failures++;
                $display("FAIL %s cyc=%0d spk/busy/done got=%b%b%b want=%b%b%b", name, k,
                         speaker, busy, done, q[k].spk, q[k].busy, q[k].done);
            end
            if (q[k].busy) begin
                checks++;
                if (scoreAddr !== 7'(q[k].addr)) begin
                    failures++;
                    $display("FAIL %s cyc=%0d addr got=%0d want=%0d", name, k, scoreAddr, q[k].addr);
                end
            end
            start = q[k].start; stop = q[k].stop; pause = q[k].pause;
            loop = q[k].loop; songSel = 2'(q[k].sel);
        end
    endtask

    task automatic test_reset();
        #12;
        checks += 4;
        if (speaker !== 1'b0) begin failures++; $display("FAIL reset speaker got=%b want=0", speaker); end
        if (busy !== 1'b0) begin failures++; $display("FAIL reset busy got=%b want=0", busy); end
        if (done !== 1'b0) begin failures++; $display("FAIL reset done got=%b want=0", done); end
        if (scoreAddr !== 7'd0) begin failures++; $display("FAIL reset addr got=%0d want=0", scoreAddr); end
        @(negedge clk) rstN = 1'b1;
    endtask

    task automatic test_basic();
        setBasicSong();
        q.delete(); addLaunch(0); addSong(0, 1);
        runTrace("basic", q.size());
    endtask

    task automatic test_loop();
        q.delete(); addLaunch(0); addSong(0, 3);
        runTrace("loop", q.size());
    endtask

    task automatic test_pause();
        q.delete(); addLaunch(0); addSong(0, 1); addPause(7, 30);
        runTrace("pause", q.size());
    endtask

    task automatic test_song_wrap();
        fillSong(2, OFFS);
        memKey[96] = 4'd15;
        q.delete(); addLaunch(2); addSong(2, 1);
        runTrace("wrap", q.size());
    endtask

    task automatic test_random();
        repeat (6) begin
            int s = $urandom_range(0, 3);
            fillSong(s, $urandom_range(1, 6));
            q.delete(); addLaunch(s); addSong(s, $urandom_range(1, 2));
            if ($urandom_range(0, 1) == 1) addPause($urandom_range(1, q.size() - 4), $urandom_range(1, 8));
            runTrace("random", q.size());
        end
    endtask

    task automatic test_stop();
        for (int r = 0; r < 2; r++) begin
            int c;
            q.delete(); addLaunch(0); addSong(0, 1);
            c = $urandom_range(1, q.size() - 3);
            q = q[0:c];
            q[c].stop = 1;
            q[c].start = r == 1;
            q[c].sel = 1;
            addIdle(5);
            runTrace(r == 1 ? "stop_start" : "stop", q.size());
        end
    endtask

    task automatic test_back_to_back();
        fillSong(1, 3);
        fillSong(3, 2);
        for (int r = 0; r < 2; r++) begin
            int c, endIdx;
            q.delete(); addLaunch(1); addSong(1, 1);
            endIdx = q.size() - 3;
            c = r == 1 ? endIdx : $urandom_range(1, endIdx - 1);
            q = q[0:c];
            q[c].start = 1;
            q[c].sel = 3;
            addSong(3, 1);
            q[c + 1].done = c == endIdx;
            runTrace(r == 1 ? "restart_at_end" : "restart", q.size());
        end
    endtask

    task automatic test_async_reset();
        setBasicSong();
        q.delete(); addLaunch(0); addSong(0, 1);
        runTrace("pre_reset", 38);
        #2 rstN = 1'b0;
        #1;
        checks++;
        if ({speaker, busy, done, scoreAddr} !== 10'd0) begin
            failures++;
            $display("FAIL async_reset spk/busy/done/addr got=%b%b%b/%0d want=000/0", speaker, busy, done, scoreAddr);
        end
        @(negedge clk) rstN = 1'b1;
        q.delete(); addLaunch(0); addSong(0, 1);
        runTrace("post_reset", q.size());
    endtask

    initial begin
        for (int s = 0; s < 4; s++) fillSong(s, 3);
        test_reset();
        test_basic();
        test_loop();
        test_pause();
        test_song_wrap();
        test_random();
        test_stop();
        test_back_to_back();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
